adv7513_reg_dump: RTL and testbench

Register-dump sequencer that sits directly upstream of the ADV7513 register-read block. It walks an 8-bit register address range and issues one read per address through the reader's start/done handshake. Each returned byte is captured into a small show-ahead FIFO as an {address, data, timeout} record, and records leave through a valid/ready stream to the debug/UART path. Reads that never complete are bounded by a per-read timeout, so one dead register cannot hang a dump.

---
 rtl/adv7513_reg_dump.sv | 178 +++++++++++++++++
 tb/tb_adv7513_reg_dump.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adv7513_reg_dump.sv
// Register-dump sequencer: walks an address range through the ADV7513 reader's
// start/done handshake and queues {addr, data, timeout} records in a show-ahead FIFO.
module adv7513_reg_dump #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       go_i,
  input  logic [7:0] first_addr_i,
  input  logic [7:0] last_addr_i,
  output logic       busy_o,
  output logic       dump_done_o,
  output logic       error_o,
  output logic       rd_start_o,
  output logic [7:0] rd_addr_o,
  input  logic       rd_done_i,
  input  logic [7:0] rd_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_addr_o,
  output logic [7:0] out_data_o,
  output logic       out_timeout_o
);

  localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [19:0] TimerLast = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0] CntOne  = (PtrW + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StArm,
    StWait,
    StCapture,
    StPush
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cur_addr_q, cur_addr_d;
  logic [7:0]  end_addr_q, end_addr_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_to_q, hold_to_d;
  logic        error_q, error_d;
  logic [19:0] timer_q, timer_d;

  logic [16:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            fifo_full, push, pop, dump_done;
  logic [16:0]     head;

  assign fifo_full = (count_q == FullCnt);
  assign pop       = (count_q != '0) && out_ready_i;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    end_addr_d  = end_addr_q;
    hold_data_d = hold_data_q;
    hold_to_d   = hold_to_q;
    error_d     = error_q;
    timer_d     = timer_q;
    push        = 1'b0;
    dump_done   = 1'b0;
    case (state_q)
      StIdle: begin
        if (go_i) begin
          cur_addr_d = first_addr_i;
          end_addr_d = last_addr_i;
          error_d    = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StArm;
      end
      StArm: begin
        timer_d = timer_q + 20'd1;
        if (timer_q == TimerLast) begin
          hold_data_d = 8'h00;
          hold_to_d   = 1'b1;
          error_d     = 1'b1;
          state_d     = StPush;
        end else if (!rd_done_i) begin
          // A done level from the previous read must drop before we trust a new one.
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + 20'd1;
        if (rd_done_i) begin
          state_d = StCapture;
        end else if (timer_q == TimerLast) begin
          hold_data_d = 8'h00;
          hold_to_d   = 1'b1;
          error_d     = 1'b1;
          state_d     = StPush;
        end
      end
      StCapture: begin
        // Reader data is registered, so it is valid one cycle after done.
        hold_data_d = rd_data_i;
        hold_to_d   = 1'b0;
        state_d     = StPush;
      end
      StPush: begin
        if (!fifo_full) begin
          push = 1'b1;
          if (cur_addr_q == end_addr_q) begin
            dump_done = 1'b1;
            state_d   = StIdle;
          end else begin
            cur_addr_d = cur_addr_q + 8'd1;
            state_d    = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      end_addr_q  <= '0;
      hold_data_q <= '0;
      hold_to_q   <= 1'b0;
      error_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      end_addr_q  <= end_addr_d;
      hold_data_q <= hold_data_d;
      hold_to_q   <= hold_to_d;
      error_q     <= error_d;
      timer_q     <= timer_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cur_addr_q, hold_data_q, hold_to_q};
  end

  assign head = mem_q[rd_ptr_q];

  assign busy_o        = (state_q != StIdle);
  assign dump_done_o   = dump_done;
  assign error_o       = error_q;
  assign rd_start_o    = (state_q == StIssue);
  assign rd_addr_o     = cur_addr_q;
  assign out_valid_o   = (count_q != '0);
  // Outputs read zero when empty so stale storage never shows after reset.
  assign out_addr_o    = out_valid_o ? head[16:9] : 8'h00;
  assign out_data_o    = out_valid_o ? head[8:1]  : 8'h00;
  assign out_timeout_o = out_valid_o ? head[0]    : 1'b0;

endmodule

// File: tb/tb_adv7513_reg_dump.sv
// Self-checking bench for adv7513_reg_dump: behavioural reader model plus a
// record scoreboard fed at go time and drained from the output stream.
module tb_adv7513_reg_dump;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [7:0] first_addr = '0, last_addr = '0;
  logic       busy, dump_done, error, rd_start, rd_done, out_valid, out_timeout;
  logic       out_ready = 1'b0;
  logic [7:0] rd_addr, rd_data, out_addr, out_data;

  always #5 clk = ~clk;

  adv7513_reg_dump #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .go_i         (go),
    .first_addr_i (first_addr),
    .last_addr_i  (last_addr),
    .busy_o       (busy),
    .dump_done_o  (dump_done),
    .error_o      (error),
    .rd_start_o   (rd_start),
    .rd_addr_o    (rd_addr),
    .rd_done_i    (rd_done),
    .rd_data_i    (rd_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_addr_o   (out_addr),
    .out_data_o   (out_data),
    .out_timeout_o(out_timeout)
  );

  int checks = 0;
  int failures = 0;

  // Reader model knobs
  int         m_lat = 10;
  logic [7:0] m_key = 8'h00;
  bit         m_stale = 1'b0;
  bit         m_dead_en = 1'b0;
  logic [7:0] m_dead = 8'h00;

  logic [7:0] rdr_addr;
  int         rdr_cnt;
  bit         rdr_act;

  always @(posedge clk) begin
    if (reset) begin
      rd_done <= 1'b0;
      rd_data <= 8'h00;
      rdr_act <= 1'b0;
      rdr_cnt <= 0;
      rdr_addr <= 8'h00;
    end else if (rd_start) begin
      rdr_act  <= 1'b1;
      rdr_cnt  <= 1;
      rdr_addr <= rd_addr;
      if (!m_stale) rd_done <= 1'b0;
    end else if (rdr_act) begin
      rdr_cnt <= rdr_cnt + 1;
      if (m_stale && rdr_cnt == 2) rd_done <= 1'b0;
      if (rdr_cnt == m_lat - 1 && !(m_dead_en && rdr_addr == m_dead)) begin
        rd_done <= 1'b1;
        rd_data <= rdr_addr ^ m_key;
        rdr_act <= 1'b0;
      end
    end
  end

  // Monitor: collects observed records and handshake events
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  logic [7:0]  start_addr_q[$];
  int          start_cyc_q[$];
  int          cyc = 0;
  int          n_start = 0;
  int          n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) obs_q.push_back({out_addr, out_data, out_timeout});
      if (rd_start) begin
        n_start++;
        start_addr_q.push_back(rd_addr);
        start_cyc_q.push_back(cyc);
      end
      if (dump_done) n_done++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_dump(input logic [7:0] f, input logic [7:0] l);
    int n;
    logic [7:0] a;
    first_addr = f;
    last_addr  = l;
    go = 1'b1;
    tick(1);
    go = 1'b0;
    n = ((int'(l) - int'(f)) & 255) + 1;
    a = f;
    for (int i = 0; i < n; i++) begin
      if (m_dead_en && a == m_dead) exp_q.push_back({a, 8'h00, 1'b1});
      else exp_q.push_back({a, a ^ m_key, 1'b0});
      a = a + 8'd1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_records(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(3);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    checks++;
    if ({busy, dump_done, error, rd_start, rd_addr} !== 12'h000) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b done=%b err=%b start=%b addr=%h want 0 0 0 0 00",
               busy, dump_done, error, rd_start, rd_addr);
    end
    checks++;
    if ({out_valid, out_addr, out_data, out_timeout} !== 18'h0) begin
      failures++;
      $display("FAIL reset_out got v=%b a=%h d=%h t=%b want 0 00 00 0",
               out_valid, out_addr, out_data, out_timeout);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single;
    int s0, d0;
    bit ok, ok2;
    logic [16:0] e, o;
    m_key = 8'h13; m_lat = 40; out_ready = 1'b1;
    s0 = n_start; d0 = n_done;
    start_dump(8'h00, 8'h00);
    wait_idle(500, ok);
    wait_records(1, 100, ok2);
    checks++;
    if (!ok || !ok2) begin failures++; $display("FAIL single_timeout got idle=%b rec=%b want 1 1", ok, ok2); end
    checks++;
    if (n_start - s0 !== 1) begin failures++; $display("FAIL single_starts got %0d want 1", n_start - s0); end
    checks++;
    if (n_done - d0 !== 1) begin failures++; $display("FAIL single_done got %0d want 1", n_done - d0); end
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL single_error got %b want 0", error); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL single_rec got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure;
    int s0;
    bit ok;
    logic [16:0] e, o;
    m_key = 8'hA5; m_lat = 10; out_ready = 1'b0;
    s0 = n_start;
    start_dump(8'h40, 8'h47);
    tick(2000);
    // Four reads fill the FIFO; the fifth is captured and held in PUSH.
    checks++;
    if (n_start - s0 !== 5) begin failures++; $display("FAIL bp_starts got %0d want 5", n_start - s0); end
    checks++;
    if ({busy, out_valid, out_addr} !== {2'b11, 8'h40}) begin
      failures++; $display("FAIL bp_stall got busy=%b v=%b a=%h want 1 1 40", busy, out_valid, out_addr);
    end
    checks++;
    if (obs_q.size() !== 0) begin failures++; $display("FAIL bp_leak got %0d want 0", obs_q.size()); end
    out_ready = 1'b1;
    wait_records(8, 1000, ok);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL bp_rec got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stale_done;
    bit ok;
    logic [16:0] e, o;
    m_key = 8'h5A; m_lat = 12; m_stale = 1'b1; out_ready = 1'b1;
    start_dump(8'h20, 8'h23);
    wait_idle(1000, ok);
    wait_records(4, 100, ok);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL stale_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL stale_rec got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    m_stale = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    int c45, c46;
    logic [16:0] e, o;
    m_key = 8'h3C; m_lat = 10; m_dead_en = 1'b1; m_dead = 8'h45; out_ready = 1'b1;
    start_addr_q.delete(); start_cyc_q.delete();
    start_dump(8'h44, 8'h46);
    wait_idle(1000, ok);
    wait_records(3, 100, ok);
    c45 = -1; c46 = -1;
    foreach (start_addr_q[i]) begin
      if (start_addr_q[i] == 8'h45) c45 = start_cyc_q[i];
      if (start_addr_q[i] == 8'h46) c46 = start_cyc_q[i];
    end
    // 64 timeout cycles after ISSUE, then PUSH, then the next ISSUE.
    checks++;
    if (c46 - c45 !== 66 || c45 < 0) begin
      failures++; $display("FAIL to_latency got %0d want 66", c46 - c45);
    end
    checks++;
    if (error !== 1'b1) begin failures++; $display("FAIL to_error got %b want 1", error); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL to_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL to_rec got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    m_dead_en = 1'b0;
  endtask

  task automatic test_wrap;
    bit ok;
    logic [16:0] e, o;
    m_key = 8'h77; m_lat = 6; out_ready = 1'b1;
    start_dump(8'hFE, 8'h01);
    wait_idle(500, ok);
    wait_records(4, 100, ok);
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL wrap_error got %b want 0", error); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_rec got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    m_key = 8'h81; m_lat = 5;
    start_dump(8'h10, 8'h0F);
    wait_idle(5000, ok);
    wait_records(256, 200, ok);
    checks++;
    if (obs_q.size() !== 256 || exp_q.size() !== 256) begin
      failures++; $display("FAIL full_count got %0d want 256", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL full_rec got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_go_busy_and_reset;
    int s0;
    bit ok;
    logic [16:0] e, o;
    m_key = 8'h11; m_lat = 50; out_ready = 1'b1;
    s0 = n_start;
    start_dump(8'h30, 8'h33);
    tick(15);
    first_addr = 8'h90; last_addr = 8'h91; go = 1'b1;
    tick(1);
    go = 1'b0;
    wait_idle(1000, ok);
    wait_records(4, 100, ok);
    checks++;
    if (n_start - s0 !== 4) begin failures++; $display("FAIL gobusy_starts got %0d want 4", n_start - s0); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL gobusy_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL gobusy_rec got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    // Reset mid-dump with records sitting in the FIFO
    m_lat = 30; out_ready = 1'b0;
    start_dump(8'h50, 8'h57);
    tick(100);
    reset = 1'b1;
    tick(1);
    checks++;
    if ({busy, dump_done, error, rd_start, rd_addr, out_valid, out_addr, out_data, out_timeout}
        !== 30'h0) begin
      failures++;
      $display("FAIL midreset got busy=%b start=%b addr=%h v=%b oa=%h od=%h want all zero",
               busy, rd_start, rd_addr, out_valid, out_addr, out_data);
    end
    reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b1;
    tick(5);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_empty got %b want 0", out_valid); end
    m_lat = 8; m_key = 8'h2B;
    start_dump(8'h60, 8'h60);
    wait_idle(500, ok);
    wait_records(1, 100, ok);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL postreset_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL postreset_rec got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stale_done();
    test_timeout();
    test_wrap();
    test_go_busy_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
